alu_share_arb: RTL
==================

Name: alu_share_arb

Overview:
- Shares the single combinational `alu` datapath between two requesters, e.g. the integer pipeline (port 0) and a future address/branch unit (port 1).
- Arbitrates round-robin and holds one operation in flight.
- Registers operands and result, and returns the result with the ID of the requester that issued it.
- Sits between the issue logic and the `alu` instance.

Parameters:
- WIDTH, 32, operand/result width; must match the `alu` instance.
- CTRL_W, 4, ALU_ctrl width.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  port 0 request valid
- req0_ready  output  1  port 0 request accepted this cycle
- req0_ctrl  input  CTRL_W  port 0 ALU op code
- req0_a  input  WIDTH  port 0 operand A
- req0_b  input  WIDTH  port 0 operand B
- req1_valid / req1_ready / req1_ctrl / req1_a / req1_b  same as port 0, for port 1
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts result
- rsp_data  output  WIDTH  ALU result
- rsp_id  output  1  originating port (0/1)
- rsp_err  output  1  illegal-op flag (see Optional Feature)

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high: rst is sampled on the rising edge of clk.
- Reset values:
  - state=IDLE
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0
  - req0_ready=req1_ready=0 during the reset cycle
  - op_ctrl/op_a/op_b=0
  - last_grant=1, so port 0 wins the first tie.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready = grant to N, combinationally from the valids and last_grant.
  - Only one ready is high per cycle.
  - A single valid requester is granted.
  - If both are valid, the port != last_grant is granted.
  - On handshake (valid&ready) at edge N: latch ctrl/a/b into op_ctrl/op_a/op_b, latch the port into op_id, set last_grant=port, go to EXEC.
  - Request inputs need not remain stable after acceptance.
- EXEC:
  - `alu` sees op_ctrl, op_a, op_b.
  - At edge N+1: capture the ALU result into rsp_data and op_id into rsp_id, set rsp_valid=1, go to RESP.
  - Both readys are 0.
- RESP:
  - rsp_valid=1. rsp_data, rsp_id and rsp_err are held stable until rsp_ready.
  - When rsp_ready=1: rsp_valid is 0 from the next cycle and state returns to IDLE.
  - Both readys are 0 in RESP.
- Latency and throughput:
  - Accept-to-rsp_valid latency is exactly 2 cycles.
  - Minimum issue interval is 3 cycles with rsp_ready tied high.
- Fairness: under continuous dual requests, grants strictly alternate 0,1,0,1…
- Width rules: result is the `alu` output truncated/extended by `alu` itself. The arbiter adds no arithmetic.
- Reset mid-operation (EXEC or RESP): the in-flight op is dropped silently with no response, and all registers return to their reset values.
- Simultaneous events:
  - A request valid during EXEC/RESP is held off (ready=0).
  - Requesters must keep valid asserted; dropping valid while not granted is allowed (no-request).

Optional Feature:
- Macro: ALU_SHARE_ARB_ILLEGAL_OP_EN.
- Defined:
  - ctrl > 4'hB is illegal.
  - It is still accepted, but the `alu` is driven with ctrl 4'h0 and operands 0.
  - The response carries rsp_data=0 and rsp_err=1, with normal latency.
- Undefined:
  - Any ctrl is passed to the `alu` unchanged.
  - rsp_err is constant 0.

Decomposition:
- Shared package `alu_pkg`:
  - ALU_WIDTH=32, ALU_CTRL_W=4, ALU_OP_MAX=4'hB
  - FSM state encoding: IDLE=2'd0, EXEC=2'd1, RESP=2'd2
- Sub-module: the existing `alu`, instantiated once inside this block.
- Arbitration is a small combinational block internal to the module; no separate arbiter module.

Test Plan:
- Single request: after reset, port0 sends A=0x000000B5, B=0x0000000D, ctrl=4'h0 → req0_ready=1 in the same cycle. rsp_valid rises 2 cycles later with rsp_data = `alu`(0,0xB5,0xD) model and rsp_id=0.
- Tie and round-robin: both ports valid continuously with rsp_ready=1 → grant order 0,1,0,1. Each response has the correct rsp_id and per-port operands, and a new accept occurs every 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_data/rsp_id stay stable, and both readys stay 0 throughout. Raising rsp_ready leads to IDLE the next cycle.
- Op sweep: ctrl 4'h0..4'hB with A=0xFFFFFFFF, B=0xFFFFFFFF, alternating ports → every rsp_data matches the `alu` model.
- Reset mid-op: assert rst for 1 cycle during EXEC → no rsp_valid ever appears for that op, and all outputs are 0. The next tie is granted to port 0.
- Illegal op: with ALU_SHARE_ARB_ILLEGAL_OP_EN, ctrl=4'hE → rsp_err=1, rsp_data=0. Without the macro, rsp_err=0 and rsp_data = `alu` model for ctrl 4'hE.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU package: widths, op encoding and arbiter FSM states.
// Used by alu and alu_share_arb.
package alu_pkg;

  localparam int         ALU_WIDTH  = 32;
  localparam int         ALU_CTRL_W = 4;
  localparam logic [3:0] ALU_OP_MAX = 4'hB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_SLL   = 4'h5,
    OP_SRL   = 4'h6,
    OP_SRA   = 4'h7,
    OP_SLT   = 4'h8,
    OP_SLTU  = 4'h9,
    OP_PASSB = 4'hA,
    OP_ANDN  = 4'hB
  } alu_op_t;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; codes above ALU_OP_MAX yield zero.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int CTRL_W = ALU_CTRL_W
) (
  input  logic [CTRL_W-1:0] ctrl,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic [WIDTH-1:0]  y
);

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0] shamt;
  logic            lt_s;
  logic            lt_u;

  assign shamt = b[SH_W-1:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  always_comb begin
    y = '0;
    case (ctrl)
      OP_ADD:   y = a + b;
      OP_SUB:   y = a - b;
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_SLL:   y = a << shamt;
      OP_SRL:   y = a >> shamt;
      OP_SRA:   y = $unsigned($signed(a) >>> shamt);
      OP_SLT:   y = {{(WIDTH-1){1'b0}}, lt_s};
      OP_SLTU:  y = {{(WIDTH-1){1'b0}}, lt_u};
      OP_PASSB: y = b;
      OP_ANDN:  y = a & ~b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin share of one alu between two requesters, one op in flight.
// Optional: ALU_SHARE_ARB_ILLEGAL_OP_EN flags ctrl > ALU_OP_MAX via rsp_err.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int CTRL_W = ALU_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              rsp_id,
  output logic              rsp_err
);

  arb_state_t        state;
  logic              last_grant;
  logic              op_id;
  logic [CTRL_W-1:0] op_ctrl;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [WIDTH-1:0]  alu_y;

  logic              grant0;
  logic              grant1;
  logic              accept;
  logic [CTRL_W-1:0] in_ctrl;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
`ifdef ALU_SHARE_ARB_ILLEGAL_OP_EN
  logic              in_err;
  logic              op_err;
`endif

  // On a tie the port that did not win last time is granted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && state == IDLE) begin
      if (req0_valid && (!req1_valid || last_grant))
        grant0 = 1'b1;
      else if (req1_valid)
        grant1 = 1'b1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;

  always_comb begin
    in_ctrl = grant1 ? req1_ctrl : req0_ctrl;
    in_a    = grant1 ? req1_a    : req0_a;
    in_b    = grant1 ? req1_b    : req0_b;
`ifdef ALU_SHARE_ARB_ILLEGAL_OP_EN
    in_err  = in_ctrl > CTRL_W'(ALU_OP_MAX);
    if (in_err) begin
      in_ctrl = '0;
      in_a    = '0;
      in_b    = '0;
    end
`endif
  end

  alu #(
    .WIDTH  (WIDTH),
    .CTRL_W (CTRL_W)
  ) u_alu (
    .ctrl (op_ctrl),
    .a    (op_a),
    .b    (op_b),
    .y    (alu_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_id      <= 1'b0;
      op_ctrl    <= '0;
      op_a       <= '0;
      op_b       <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
`ifdef ALU_SHARE_ARB_ILLEGAL_OP_EN
      op_err     <= 1'b0;
      rsp_err    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_ctrl    <= in_ctrl;
            op_a       <= in_a;
            op_b       <= in_b;
            op_id      <= grant1;
            last_grant <= grant1;
`ifdef ALU_SHARE_ARB_ILLEGAL_OP_EN
            op_err     <= in_err;
`endif
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= alu_y;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
`ifdef ALU_SHARE_ARB_ILLEGAL_OP_EN
          rsp_err   <= op_err;
`endif
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef ALU_SHARE_ARB_ILLEGAL_OP_EN
  assign rsp_err = 1'b0;
`endif

endmodule
